// File: rtl/wb_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// wb_arbiter : register-file writeback arbiter with long-latency FIFO and RAW
//              scoreboard of destination registers with writes in flight.
// Revision   : 1.0
// ----------------------------------------------------------------------------
module wb_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    alu_valid,
  output logic                    alu_ready,
  input  logic [4:0]              alu_rd,
  input  logic [31:0]             alu_data,
  input  logic                    mem_valid,
  output logic                    mem_ready,
  input  logic [4:0]              mem_rd,
  input  logic [31:0]             mem_data,
  input  logic                    iss_valid,
  input  logic [4:0]              iss_rd,
  input  logic [4:0]              q_rd1,
  input  logic [4:0]              q_rd2,
  output logic                    q_busy1,
  output logic                    q_busy2,
  output logic                    rf_we,
  output logic [4:0]              rf_waddr,
  output logic [31:0]             rf_wdata,
  output logic [$clog2(DEPTH):0]  fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [4:0]    fifo_rd   [DEPTH];
  logic [31:0]   fifo_data [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  logic          full;
  logic          empty;
  logic          enq;
  logic          deq;
  logic          sel_valid;
  logic [4:0]    sel_rd;
  logic [31:0]   sel_data;
  logic          wr_en;

  logic [31:0]   pending;
  logic [31:0]   set_vec;
  logic [31:0]   clr_vec;

  assign full       = (count == FULL_COUNT);
  assign empty      = (count == '0);
  assign alu_ready  = ~full;
  assign mem_ready  = ~full;
  assign enq        = mem_valid & ~full;
  assign fifo_count = count;

  // A full FIFO outranks the ALU so a steady ALU stream cannot starve it forever.
  always_comb begin
    sel_valid = 1'b0;
    deq       = 1'b0;
    sel_rd    = fifo_rd[rd_ptr];
    sel_data  = fifo_data[rd_ptr];
    if (full) begin
      sel_valid = 1'b1;
      deq       = 1'b1;
    end else if (alu_valid) begin
      sel_valid = 1'b1;
      sel_rd    = alu_rd;
      sel_data  = alu_data;
    end else if (!empty) begin
      sel_valid = 1'b1;
      deq       = 1'b1;
    end
  end

  assign wr_en = sel_valid && (sel_rd != 5'd0);

  always_ff @(posedge clk) begin
    if (enq) begin
      fifo_rd[wr_ptr]   <= mem_rd;
      fifo_data[wr_ptr] <= mem_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rf_we    <= 1'b0;
      rf_waddr <= 5'd0;
      rf_wdata <= 32'd0;
    end else begin
      rf_we <= wr_en;
      if (wr_en) begin
        rf_waddr <= sel_rd;
        rf_wdata <= sel_data;
      end
    end
  end

  // Set is applied after clear so a re-issue on the retiring edge keeps the bit.
  assign set_vec = (iss_valid && (iss_rd != 5'd0)) ? (32'd1 << iss_rd) : 32'd0;
  assign clr_vec = rf_we ? (32'd1 << rf_waddr) : 32'd0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending <= 32'd0;
    end else begin
      pending <= (pending & ~clr_vec) | set_vec;
    end
  end

  assign q_busy1 = pending[q_rd1];
  assign q_busy2 = pending[q_rd2];

endmodule
`default_nettype wire
